// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared types and constants for the game_logic slice, including
//               the PS/2 receiver state encoding and well-known scan codes.
// Revision    : 1.0  initial PS/2 receiver additions
// ============================================================================
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_ENTER = 8'h5A;

    // Parity bit that makes {byte, parity} carry an odd number of ones.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_sync_filter
// Description : Two-flop synchronisers for the PS/2 lines, optional clock
//               stability filter (PS2_GLITCH_FILTER_EN) and fall detection.
// Revision    : 1.0  initial release
// ============================================================================
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall_tick
);

`ifdef PS2_GLITCH_FILTER_EN
    localparam bit c_FILTER_EN = 1'b1;
`else
    localparam bit c_FILTER_EN = 1'b0;
`endif

    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;
    logic       w_clk_level;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    generate
        if (c_FILTER_EN && (FILTER_LEN > 1)) begin : g_filter
            localparam int c_CW = $clog2(FILTER_LEN);
            localparam logic [c_CW-1:0] c_CLAST = c_CW'(FILTER_LEN - 1);

            logic            r_level;
            logic [c_CW-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_level <= 1'b1;
                    r_cnt   <= '0;
                end else if (r_clk_sync[1] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CLAST) begin
                    r_level <= r_clk_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end

            assign w_clk_level = r_level;
        end else begin : g_bypass
            assign w_clk_level = r_clk_sync[1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_clk_level;
        end
    end

    assign fall_tick = r_clk_prev & ~w_clk_level;
    assign data_s    = r_data_sync[1];

endmodule
`default_nettype wire

// File: rtl/ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keycode_rx
// Description : PS/2 device-to-host frame receiver publishing {prev, last}
//               keycode bytes. Optional macro: PS2_GLITCH_FILTER_EN.
// Revision    : 1.0  initial release
// ============================================================================
module ps2_keycode_rx
    import vga_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65_000,
    parameter int FILTER_LEN     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        keycode_valid,
    output logic        frame_err
);

    localparam int              c_TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic            w_data_s;
    logic            w_fall_tick;
    logic            w_frame_ok;

    ps2_rx_state     r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shreg;
    logic            r_parity;
    logic [c_TW-1:0] r_tcnt;
    logic [15:0]     r_keycode;
    logic            r_keycode_valid;
    logic            r_frame_err;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_s    (w_data_s),
        .fall_tick (w_fall_tick)
    );

    // Evaluated with the stop bit currently on the data line.
    assign w_frame_ok = w_data_s && (ps2_odd_parity(r_shreg) == r_parity);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_bit_cnt       <= 3'd0;
            r_shreg         <= 8'h00;
            r_parity        <= 1'b0;
            r_tcnt          <= '0;
            r_keycode       <= 16'h0000;
            r_keycode_valid <= 1'b0;
            r_frame_err     <= 1'b0;
        end else begin
            r_keycode_valid <= 1'b0;
            r_frame_err     <= 1'b0;

            // A falling edge always beats a coincident timeout expiry.
            if (w_fall_tick) begin
                r_tcnt <= '0;
                case (r_state)
                    IDLE: begin
                        if (!w_data_s) begin
                            r_state   <= DATA;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_shreg <= {w_data_s, r_shreg[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        r_parity <= w_data_s;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        if (w_frame_ok) begin
                            r_keycode       <= {r_keycode[7:0], r_shreg};
                            r_keycode_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state == IDLE) begin
                r_tcnt <= '0;
            end else if (r_tcnt == c_TLAST) begin
                r_state     <= IDLE;
                r_frame_err <= 1'b1;
            end else begin
                r_tcnt <= r_tcnt + c_TW'(1);
            end
        end
    end

    assign keycode       = r_keycode;
    assign keycode_valid = r_keycode_valid;
    assign frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keycode_rx
// Description : Directed self-checking bench for ps2_keycode_rx.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_keycode_rx;
    import vga_pkg::*;

    localparam int TO = 300;
    localparam int HP = 12;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keycode;
    logic        keycode_valid;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int v0, e0;

    ps2_keycode_rx #(
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .keycode       (keycode),
        .keycode_valid (keycode_valid),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (keycode_valid) n_valid <= n_valid + 1;
        if (frame_err)     n_err   <= n_err + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clk(HP);
        ps2_clk = 1'b0;
        wait_clk(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stp);
        ps2_data = 1'b1;
        wait_clk(2 * HP);
    endtask

    task automatic snap();
        wait_clk(2);
        v0 = n_valid;
        e0 = n_err;
    endtask

    initial begin
        wait_clk(3);
        check("reset_keycode", int'(keycode), 16'h0000);
        check("reset_valid", int'(keycode_valid), 0);
        check("reset_err", int'(frame_err), 0);
        rst_n = 1'b1;
        wait_clk(5);

        // 5A has four ones -> parity 1
        snap();
        send_frame(PS2_ENTER, 1'b1, 1'b1);
        check("single_keycode", int'(keycode), 16'h005A);
        check("single_valid_cnt", n_valid - v0, 1);
        check("single_err_cnt", n_err - e0, 0);

        snap();
        send_frame(PS2_BREAK, 1'b1, 1'b1);
        check("break_keycode", int'(keycode), 16'h5AF0);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("release_keycode", int'(keycode), 16'hF05A);
        check("release_valid_cnt", n_valid - v0, 2);

        // 1C has three ones -> correct parity 0
        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        check("parity_err_cnt", n_err - e0, 1);
        check("parity_keycode_hold", int'(keycode), 16'hF05A);
        check("parity_valid_cnt", n_valid - v0, 0);

        snap();
        send_frame(8'h1C, 1'b0, 1'b0);
        check("stop_err_cnt", n_err - e0, 1);
        check("stop_keycode_hold", int'(keycode), 16'hF05A);

        send_frame(8'h1C, 1'b0, 1'b1);
        check("history_1", int'(keycode), 16'h5A1C);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("history_repeat", int'(keycode), 16'h1C1C);

        snap();
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_clk(2 * HP);
        check("bad_start_err_cnt", n_err - e0, 1);

        // Timeout after four data bits of 8'h29
        snap();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_clk(TO + 50);
        check("timeout_err_cnt", n_err - e0, 1);
        check("timeout_valid_cnt", n_valid - v0, 0);
        check("timeout_keycode_hold", int'(keycode), 16'h1C1C);
        send_frame(8'h29, 1'b0, 1'b1);
        check("after_timeout_low", int'(keycode[7:0]), 8'h29);
        check("after_timeout_full", int'(keycode), 16'h1C29);

        // Reset during data bit 5
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(PS2_ENTER[i]);
        rst_n = 1'b0;
        #1;
        check("midreset_keycode", int'(keycode), 16'h0000);
        check("midreset_valid", int'(keycode_valid), 0);
        check("midreset_err", int'(frame_err), 0);
        ps2_data = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        snap();
        send_frame(8'h5A, 1'b1, 1'b1);
        check("post_reset_keycode", int'(keycode), 16'h005A);
        check("post_reset_err_cnt", n_err - e0, 0);

        // Short low pulse on ps2_clk while idle
        snap();
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        wait_clk(2);
        ps2_clk  = 1'b1;
        wait_clk(20);
`ifdef PS2_GLITCH_FILTER_EN
        check("glitch_err_cnt", n_err - e0, 0);
`else
        check("glitch_err_cnt", n_err - e0, 1);
`endif
        check("glitch_valid_cnt", n_valid - v0, 0);
        send_frame(8'h29, 1'b0, 1'b1);
        check("after_glitch_keycode", int'(keycode), 16'h5A29);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
